// File: rtl/noc_pkg.sv
// Shared NoC definitions for network-interface transmitters.
//   FLIT_WIDTH    : default flit / local word width
//   flit_t        : one flit at the default width
//   ni_tx_state_t : packet transmitter sequencing states
package noc_pkg;

    localparam int FLIT_WIDTH = 16;

    typedef logic [FLIT_WIDTH-1:0] flit_t;

    typedef enum logic [2:0] {
        IDLE,
        HEADER,
        SIZE,
        PAYLOAD,
        DRAIN
    } ni_tx_state_t;

endpackage

// File: rtl/ni_packet_tx_if.sv
// Bundle of the local-core request/payload handshake and the router link
// of a NI packet transmitter.
//   send_start/send_dest/send_size, busy, done : packet request/status
//   pl_valid/pl_data, pl_ready                 : payload word stream
//   tx/data_out, credit_i                      : flit link toward router input port
// Modports: master = core + router side, slave = the transmitter.
interface ni_packet_tx_if #(
    parameter int FLIT_WIDTH = noc_pkg::FLIT_WIDTH
);

    logic                  send_start;
    logic [FLIT_WIDTH-1:0] send_dest;
    logic [FLIT_WIDTH-1:0] send_size;
    logic                  busy;
    logic                  done;

    logic                  pl_valid;
    logic [FLIT_WIDTH-1:0] pl_data;
    logic                  pl_ready;

    logic                  tx;
    logic [FLIT_WIDTH-1:0] data_out;
    logic                  credit_i;

    modport master (
        output send_start, send_dest, send_size, pl_valid, pl_data, credit_i,
        input  busy, done, pl_ready, tx, data_out
    );

    modport slave (
        input  send_start, send_dest, send_size, pl_valid, pl_data, credit_i,
        output busy, done, pl_ready, tx, data_out
    );

endinterface

// File: rtl/ni_packet_tx_flit_out_reg.sv
// Single-flit output holding register for credit-based NI transmitters.
//   clock, reset      : rising-edge clock, async active-low reset
//   credit_i          : router can accept the held flit this cycle
//   push_valid/data   : flit offered by the sequencer (push_valid=0 clears tx)
//   load_ok           : register may take a new value this cycle
//   tx, data_out      : held flit toward router
module flit_out_reg #(
    parameter int FLIT_WIDTH = noc_pkg::FLIT_WIDTH
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  credit_i,
    input  logic                  push_valid,
    input  logic [FLIT_WIDTH-1:0] push_data,
    output logic                  load_ok,
    output logic                  tx,
    output logic [FLIT_WIDTH-1:0] data_out
);

    logic                  tx_q, tx_d;
    logic [FLIT_WIDTH-1:0] data_q, data_d;

    // Empty, or the held flit leaves at this edge.
    assign load_ok = !tx_q || credit_i;

    always_comb begin
        tx_d   = tx_q;
        data_d = data_q;
        if (load_ok) begin
            tx_d = push_valid;
            // A bubble only drops tx; data_out keeps the last flit.
            if (push_valid) begin
                data_d = push_data;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            tx_q   <= 1'b0;
            data_q <= '0;
        end else begin
            tx_q   <= tx_d;
            data_q <= data_d;
        end
    end

    assign tx       = tx_q;
    assign data_out = data_q;

endmodule

// File: rtl/ni_packet_tx.sv
// Network-interface packet transmitter: header flit, size flit, then payload
// words into a router local input port under credit flow control.
//   clock, reset : rising-edge clock, async active-low reset
//   clock_tx     : clock forwarded to the router
//   nif          : request/payload/router link bundle (slave side)
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for send_start; busy=0
// HEADER  | offering the latched destination as header flit
// SIZE    | offering the latched size flit
// PAYLOAD | forwarding payload words until remaining reaches zero
// DRAIN   | waiting for the last flit to leave, then done
module ni_packet_tx #(
    parameter int FLIT_WIDTH = noc_pkg::FLIT_WIDTH
) (
    input  logic          clock,
    input  logic          reset,
    output logic          clock_tx,
    ni_packet_tx_if.slave nif
);

    import noc_pkg::*;

    typedef logic [FLIT_WIDTH-1:0] word_t;

    ni_tx_state_t state_q, state_d;
    word_t        dest_q, dest_d;
    word_t        size_q, size_d;
    word_t        remaining_q, remaining_d;
    logic         busy_q, busy_d;
    logic         done_q, done_d;

    logic         load_ok;
    logic         push_valid;
    word_t        push_data;
    logic         pl_ready;

    assign clock_tx = clock;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            dest_q      <= '0;
            size_q      <= '0;
            remaining_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            dest_q      <= dest_d;
            size_q      <= size_d;
            remaining_q <= remaining_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        dest_d      = dest_q;
        size_d      = size_q;
        remaining_d = remaining_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (nif.send_start) begin
                    dest_d      = nif.send_dest;
                    size_d      = nif.send_size;
                    remaining_d = nif.send_size;
                    busy_d      = 1'b1;
                    state_d     = HEADER;
                end
            end
            HEADER: begin
                if (load_ok) begin
                    state_d = SIZE;
                end
            end
            SIZE: begin
                if (load_ok) begin
                    state_d = (remaining_q != '0) ? PAYLOAD : DRAIN;
                end
            end
            PAYLOAD: begin
                if (load_ok && nif.pl_valid) begin
                    remaining_d = remaining_q - word_t'(1);
                    if (remaining_q == word_t'(1)) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                // Last flit leaves (or already left); the flit register
                // clears tx on this same edge.
                if (load_ok) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // pl_valid reaches tx/data_out only through the flit register.
    always_comb begin
        pl_ready   = 1'b0;
        push_valid = 1'b0;
        push_data  = '0;
        unique case (state_q)
            HEADER: begin
                push_valid = 1'b1;
                push_data  = dest_q;
            end
            SIZE: begin
                push_valid = 1'b1;
                push_data  = size_q;
            end
            PAYLOAD: begin
                pl_ready   = load_ok;
                push_valid = nif.pl_valid;
                push_data  = nif.pl_data;
            end
            default: ;
        endcase
    end

    flit_out_reg #(
        .FLIT_WIDTH (FLIT_WIDTH)
    ) u_flit_out_reg (
        .clock      (clock),
        .reset      (reset),
        .credit_i   (nif.credit_i),
        .push_valid (push_valid),
        .push_data  (push_data),
        .load_ok    (load_ok),
        .tx         (nif.tx),
        .data_out   (nif.data_out)
    );

    assign nif.busy     = busy_q;
    assign nif.done     = done_q;
    assign nif.pl_ready = pl_ready;

endmodule
